// File: rtl/viterbi_backtrace_ctrl.sv
// Viterbi backtrace sequencer: walks backpointers onto the POS stack, then pops in order.
// Optional 16-bit busy-cycle counter output enabled by BT_CYCLE_COUNT_EN.
module viterbi_backtrace_ctrl #(
    parameter int word_num     = 16,
    parameter int word_num_bit = 4,
    parameter int POS_num_bit  = 4
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    start,
    input  logic [word_num_bit:0]   word_count,
    input  logic [POS_num_bit-1:0]  best_pos,
    output logic                    bp_rd,
    output logic [word_num_bit-1:0] bp_word,
    output logic [POS_num_bit-1:0]  bp_pos,
    input  logic [POS_num_bit-1:0]  bp_rdata,
    output logic                    RW_Stack_POS,
    output logic                    stack_en,
    output logic [POS_num_bit-1:0]  POS_Stack,
    input  logic [POS_num_bit-1:0]  final_POS,
    input  logic                    stack_empty,
    output logic                    busy,
    output logic                    out_valid,
    output logic [POS_num_bit-1:0]  out_pos,
    output logic [word_num_bit-1:0] out_idx,
    output logic                    done,
`ifdef BT_CYCLE_COUNT_EN
    output logic [15:0]             cycle_count,
`endif
    output logic                    err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RD, S_WT, S_TURN, S_POP, S_DONE
    } state_t;

    localparam logic [word_num_bit:0]   NMAX  = (word_num_bit+1)'(word_num);
    localparam logic [word_num_bit-1:0] ONE_I = 1;
    localparam logic [word_num_bit:0]   ONE_K = 1;

    state_t                  state_q, state_d;
    logic [word_num_bit:0]   n_q, n_d;
    logic [word_num_bit:0]   k_q, k_d;
    logic [word_num_bit-1:0] idx_q, idx_d;
    logic [POS_num_bit-1:0]  cur_q, cur_d;
    logic                    err_q, err_d;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            idx_q   <= '0;
            cur_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        k_d          = k_q;
        idx_d        = idx_q;
        cur_d        = cur_q;
        err_d        = err_q;
        bp_rd        = 1'b0;
        bp_word      = '0;
        bp_pos       = '0;
        RW_Stack_POS = 1'b1;
        stack_en     = 1'b0;
        POS_Stack    = '0;
        out_valid    = 1'b0;
        out_pos      = '0;
        out_idx      = '0;
        done         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = (word_count > NMAX);
                    if (word_count == '0 || word_count > NMAX)
                        state_d = S_DONE;
                    else
                        state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                n_d     = word_count;
                cur_d   = best_pos;
                idx_d   = word_count[word_num_bit-1:0] - ONE_I;
                state_d = S_RD;
            end
            S_RD: begin
                stack_en  = 1'b1;
                POS_Stack = cur_q;
                if (idx_q != '0) begin
                    bp_rd   = 1'b1;
                    bp_word = idx_q;
                    bp_pos  = cur_q;
                    state_d = S_WT;
                end else begin
                    state_d = S_TURN;
                end
            end
            S_WT: begin
                cur_d   = bp_rdata;
                idx_d   = idx_q - ONE_I;
                state_d = S_RD;
            end
            S_TURN: begin
                RW_Stack_POS = 1'b0;
                k_d          = '0;
                state_d      = S_POP;
            end
            S_POP: begin
                RW_Stack_POS = 1'b0;
                // an underflowing stack aborts without popping
                if (stack_empty) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    stack_en  = 1'b1;
                    out_valid = 1'b1;
                    out_pos   = final_POS;
                    out_idx   = k_q[word_num_bit-1:0];
                    k_d       = k_q + ONE_K;
                    if (k_q == n_q - ONE_K)
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign err  = err_q;

`ifdef BT_CYCLE_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (start)
                cnt_q <= '0;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cycle_count = cnt_q;
`endif

endmodule

// File: doc/viterbi_backtrace_ctrl.md
Name: viterbi_backtrace_ctrl

Overview:
Sequences the POS stack of the Viterbi tagger after the forward pass completes. The backtrace walks the backpointer table from the last word to the first, pushing one POS tag per word onto the stack. The block then turns the stack around and pops the tags, so the final tag sequence comes out in sentence order (word 0 first). It sits between the trellis/backpointer memory, the POS stack, and the downstream output consumer.

Parameters:
word_num, 16, maximum words per sentence
word_num_bit, 4, width of a word index
POS_num, 11, number of POS tags
POS_num_bit, 4, width of a POS tag

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (low = reset asserted)
start  in  1  one-cycle pulse: forward pass done, begin backtrace
word_count  in  word_num_bit+1  sentence length n, 0..word_num
best_pos  in  POS_num_bit  best final-column POS tag
bp_rd  out  1  backpointer read strobe
bp_word  out  word_num_bit  backpointer read word index
bp_pos  out  POS_num_bit  backpointer read POS row
bp_rdata  in  POS_num_bit  backpointer data, valid 1 cycle after bp_rd
RW_Stack_POS  out  1  stack mode: 1 = push, 0 = pop
stack_en  out  1  stack pointer advances only when high
POS_Stack  out  POS_num_bit  tag to push
final_POS  in  POS_num_bit  popped tag, combinational from the stack
stack_empty  in  1  stack-empty flag
busy  out  1  high from LOAD through DONE
out_valid  out  1  out_pos and out_idx are valid this cycle
out_pos  out  POS_num_bit  tagged POS, in sentence order
out_idx  out  word_num_bit  word index of out_pos
done  out  1  one-cycle completion pulse
err  out  1  sticky error flag; cleared on the next accepted start

Behaviour:
- Reset (reset low) takes effect asynchronously:
  - FSM goes to IDLE.
  - All outputs are 0, except RW_Stack_POS = 1 (push mode).
  - An operation in progress is dropped, with no done pulse.
- FSM states: IDLE, LOAD, RD, WT, TURN, POP, DONE.
- IDLE:
  - start is accepted only in IDLE; start in any other state is ignored.
  - On start with word_count = 0: go straight to DONE; no stack or backpointer activity.
  - On start with word_count > word_num: set err, go to DONE.
  - Otherwise go to LOAD.
- LOAD:
  - Latch n = word_count.
  - cur_pos <= best_pos; idx <= n-1.
- RD:
  - stack_en = 1, RW_Stack_POS = 1, POS_Stack = cur_pos (push).
  - If idx != 0: bp_rd = 1, bp_word = idx, bp_pos = cur_pos, then go to WT.
  - If idx == 0: go to TURN.
- WT:
  - cur_pos <= bp_rdata; idx <= idx-1; go to RD.
  - stack_en = 0.
- TURN:
  - One cycle with RW_Stack_POS = 0 and stack_en = 0, so the stack address mux can settle on the pop pointer.
  - Clear the pop counter k.
- POP:
  - stack_en = 1; out_valid = 1; out_pos = final_POS; out_idx = k; k increments each cycle.
  - After n pops, go to DONE.
  - If stack_empty is high in a POP cycle while k < n: set err, drop out_valid for that cycle, go to DONE.
- DONE:
  - done = 1 for one cycle, then go to IDLE.
  - RW_Stack_POS returns to 1.
- Timing, counted as cycles after the start-sampling edge, for n ≥ 1:
  - LOAD = cycle 1.
  - RD/WT = cycles 2..2n.
  - TURN = cycle 2n+1.
  - POP = cycles 2n+2..3n+1.
  - DONE = cycle 3n+2.
- Stack and output rules:
  - Exactly n pushes and n pops; stack_en is low in every other cycle.
  - Tags pass through unmodified.
  - No out_valid back-pressure: the consumer must accept one tag per cycle.

Optional Feature:
BT_CYCLE_COUNT_EN
- Defined: adds output cycle_count (16 bits).
  - Counts the cycles from LOAD through DONE inclusive; saturates at 0xFFFF.
  - Holds its value in IDLE; clears on the next accepted start; reset clears it to 0.
- Undefined: no port and no counter; all other behaviour is identical.

Test Plan:
- n=4, best_pos=3, backpointer table returns 7,2,5 for (word3,pos3), (word2,pos7), (word1,pos2) -> pushes 3,7,2,5; out_pos 5,2,7,3 with out_idx 0..3; done at cycle 14; err=0.
- n=1, best_pos=9 -> single push of 9, no bp_rd; out_pos=9 in cycle 4; done in cycle 5.
- n=0 -> done in cycle 1; stack_en, bp_rd and out_valid never assert; err=0.
- n=17 -> err=1, done next cycle, no stack activity; a following valid start clears err.
- Force stack_empty=1 on the second POP cycle with n=3 -> one out_valid, err=1, done the next cycle.
- Pull reset low during WT with n=5 -> all outputs 0 and RW_Stack_POS=1 immediately; no done; start after reset release runs normally; start pulses while busy are ignored.
